// File: rtl/spike_skew_buffer.sv
// spike_skew_buffer
//   Deskews the staggered per-neuron spike streams of one SNN layer into
//   per-timestep spike vectors. Neuron n begins its timestep 0 STAGGER*n
//   cycles after neuron 0. Spikes are stored as [timestep][neuron], and each
//   timestep is offered in order on a valid/ready stream once all of its
//   neurons have been captured. Capture never stalls; only the output waits.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             frame start; spike_in[0] is neuron 0 timestep 0 now
//   abort             synchronous frame abort (wins over start)
//   spike_in          live spike of every neuron
//   out_valid/ready   output handshake
//   spikes_out        spike vector of timestep_out
//   timestep_out      timestep being offered
//   out_last          out_valid on the final timestep
//   busy              frame in progress (CAPTURE or DRAIN)
//   done              one-cycle pulse after the final timestep transfer
//   overrun           one-cycle pulse after a start rejected while busy
//   state_dbg         FSM state (0 IDLE, 1 CAPTURE, 2 DRAIN)
//   spike_count       popcount of spikes_out (SPIKE_SKEW_BUFFER_POPCOUNT_EN)
//
// Handshake: a transfer happens on every cycle with out_valid && out_ready.
// out_valid depends only on registered state, never on out_ready. While
// out_valid is high and out_ready low, spikes_out and timestep_out are held.
//
// Configuration macro: SPIKE_SKEW_BUFFER_POPCOUNT_EN adds the spike_count
// output. Without it the port and its logic are absent.

module spike_skew_buffer #(
    parameter int NUM_NEURONS   = 64,
    parameter int NUM_TIMESTEPS = 30,
    parameter int STAGGER       = 1,
    parameter int TS_WIDTH      = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] spikes_out,
    output logic [TS_WIDTH-1:0]    timestep_out,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count,
`endif
    output logic [1:0]             state_dbg
);

    // Skew between neuron 0 and the last neuron, and index of the last capture edge.
    localparam int SKEW  = STAGGER * (NUM_NEURONS - 1);
    localparam int KLAST = SKEW + NUM_TIMESTEPS - 1;
    localparam int KW    = (KLAST > 0) ? $clog2(KLAST + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;          // index of the next capture edge
    logic [TS_WIDTH-1:0]   ts_q, ts_d;        // timestep currently offered
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_NEURONS-1:0] store_q [NUM_TIMESTEPS];
    logic [NUM_NEURONS-1:0] store_d [NUM_TIMESTEPS];

    logic          ts_complete;
    logic          is_last_ts;
    logic          xfer;
    logic          last_xfer;
    logic          start_accept;
    logic          cap_en;
    logic [KW-1:0] cap_k;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ts_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ts_q      <= ts_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset: every bit is rewritten inside each capture window.
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    // ---------------- output logic ----------------
    always_comb begin
        // After capture edge k, k_q = k+1; timestep T is complete once edge
        // T+SKEW has happened, i.e. k_q >= T+SKEW+1.
        ts_complete  = (32'(k_q) >= 32'(ts_q) + 32'(SKEW + 1));
        out_valid    = (state_q == S_DRAIN) || ((state_q == S_CAPTURE) && ts_complete);
        is_last_ts   = (ts_q == TS_WIDTH'(NUM_TIMESTEPS - 1));
        out_last     = out_valid && is_last_ts;
        busy         = (state_q != S_IDLE);
        xfer         = out_valid && out_ready;
        last_xfer    = xfer && is_last_ts;
        // A start is taken when idle, or when it lands on the final transfer.
        start_accept = start && !abort && ((state_q == S_IDLE) || last_xfer);
        timestep_out = ts_q;
        done         = done_q;
        overrun      = overrun_q;
        state_dbg    = state_q;
        spikes_out   = '0;
        for (int t = 0; t < NUM_TIMESTEPS; t++) begin
            if (ts_q == TS_WIDTH'(t)) spikes_out = store_q[t];
        end
    end

`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
    localparam int CW = $clog2(NUM_NEURONS + 1);
    always_comb begin
        spike_count = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            spike_count = spike_count + CW'(spikes_out[n]);
        end
    end
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ts_d      = ts_q;
        done_d    = last_xfer && !abort;
        overrun_d = start && busy && !last_xfer && !abort;
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            ts_d    = '0;
        end else if (start_accept) begin
            // Capture edge 0 happens on this edge; a one-edge window drains at once.
            state_d = (KLAST == 0) ? S_DRAIN : S_CAPTURE;
            k_d     = (KLAST == 0) ? '0 : KW'(1);
            ts_d    = '0;
        end else begin
            case (state_q)
                S_CAPTURE: begin
                    if (last_xfer) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        ts_d    = '0;
                    end else begin
                        if (k_q == KW'(KLAST)) state_d = S_DRAIN;
                        else                   k_d     = k_q + KW'(1);
                        if (xfer) ts_d = ts_q + TS_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (last_xfer) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        ts_d    = '0;
                    end else if (xfer) begin
                        ts_d = ts_q + TS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- capture ----------------
    // At capture edge k, neuron n delivers its timestep k - STAGGER*n.
    always_comb begin
        cap_en  = start_accept || ((state_q == S_CAPTURE) && !abort);
        cap_k   = start_accept ? '0 : k_q;
        store_d = store_q;
        if (cap_en) begin
            for (int t = 0; t < NUM_TIMESTEPS; t++) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (32'(cap_k) == 32'(t + STAGGER * n)) store_d[t][n] = spike_in[n];
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_skew_buffer.sv
module tb_spike_skew_buffer;

  localparam int N   = 4;
  localparam int TS  = 3;
  localparam int S1  = 1;
  localparam int S2  = 2;
  localparam int TW  = 2;
  localparam int KL1 = S1 * (N - 1) + TS - 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;
  logic out_ready2 = 1'b1;
  logic [N-1:0] spike_in = '0;
  logic [N-1:0] spike_in2 = '0;

  logic out_valid, out_last, busy, done, overrun;
  logic [N-1:0] spikes_out;
  logic [TW-1:0] timestep_out;
  logic [1:0] state_dbg;
  logic out_valid2, out_last2, busy2, done2, overrun2;
  logic [N-1:0] spikes_out2;
  logic [TW-1:0] timestep_out2;
  logic [1:0] state_dbg2;
`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
  logic [2:0] spike_count, spike_count2;
`endif

  always #5 clk = ~clk;

  spike_skew_buffer #(.NUM_NEURONS(N), .NUM_TIMESTEPS(TS), .STAGGER(S1), .TS_WIDTH(TW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .spike_in(spike_in),
    .out_valid(out_valid), .out_ready(out_ready), .spikes_out(spikes_out),
    .timestep_out(timestep_out), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun),
`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
    .spike_count(spike_count),
`endif
    .state_dbg(state_dbg)
  );

  spike_skew_buffer #(.NUM_NEURONS(N), .NUM_TIMESTEPS(TS), .STAGGER(S2), .TS_WIDTH(TW)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .spike_in(spike_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .spikes_out(spikes_out2),
    .timestep_out(timestep_out2), .out_last(out_last2), .busy(busy2), .done(done2),
    .overrun(overrun2),
`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
    .spike_count(spike_count2),
`endif
    .state_dbg(state_dbg2)
  );

  int cyc = 0;
  int base = 0;
  int mode = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  // mode 0: all ones; mode 1: neuron n spikes only at timestep n%3; mode 2: random.
  function automatic logic [N-1:0] gen(input int rel, input int s);
    logic [N-1:0] v;
    v = '0;
    for (int n = 0; n < N; n++) begin
      case (mode)
        0: v[n] = 1'b1;
        1: v[n] = ((rel - s * n) == (n % 3));
        default: v[n] = 1'($urandom_range(0, 1));
      endcase
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    spike_in  = gen(cyc - base, S1);
    spike_in2 = gen(cyc - base, S2);
  endtask

  task automatic begin_frame();
    base = cyc;
    spike_in  = gen(0, S1);
    spike_in2 = gen(0, S2);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // ---------------- scoreboard / model ----------------
  logic m_active, m_done, m_ovr;
  int m_c, m_ts;
  logic [N-1:0] hist [0:KL1];
  logic ev, xfer, lastx;
  logic [N-1:0] ve;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  logic [N-1:0] got2_q[$];
  int first1, first2, done_rel, last_rel, ovr_cnt, ovr_rel;
  logic done_seen, done2_seen;

  task automatic model_reset();
    m_active = 1'b0;
    m_done = 1'b0;
    m_ovr = 1'b0;
    m_c = 0;
    m_ts = 0;
  endtask

  task automatic clear_rec();
    got_q.delete();
    got2_q.delete();
    exp_q.delete();
    first1 = -1;
    first2 = -1;
    done_rel = -1;
    last_rel = -1;
    ovr_cnt = 0;
    ovr_rel = -1;
    done_seen = 1'b0;
    done2_seen = 1'b0;
  endtask

  // Timestep T is offered from cycle T + S*(N-1) + 1 of the frame onward;
  // its bit n is the spike neuron n gave in frame cycle T + S*n.
  always @(negedge clk) begin
    if (!reset) begin
      ev = m_active && (m_c >= m_ts + S1 * (N - 1) + 1);
      check("out_valid", 32'(out_valid), 32'(ev));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("out_last", 32'(out_last), 32'(ev && (m_ts == TS - 1)));
      if (ev) begin
        for (int n = 0; n < N; n++) ve[n] = hist[m_ts + S1 * n][n];
        check("timestep_out", 32'(timestep_out), 32'(m_ts));
        check("spikes_out", 32'(spikes_out), 32'(ve));
`ifdef SPIKE_SKEW_BUFFER_POPCOUNT_EN
        check("spike_count", 32'(spike_count), 32'($countones(ve)));
`endif
      end
      if (done) begin done_seen = 1'b1; done_rel = cyc - base; end
      if (overrun) begin ovr_cnt++; ovr_rel = cyc - base; end
      if (out_valid && first1 < 0) first1 = cyc - base;
      xfer  = ev && out_ready;
      lastx = xfer && (m_ts == TS - 1);
      if (xfer) got_q.push_back(spikes_out);
      if (lastx) last_rel = cyc - base;
      // advance the model across the coming edge
      m_done = lastx && !abort;
      m_ovr  = start && m_active && !lastx && !abort;
      if (abort) begin
        m_active = 1'b0;
      end else if (start && (!m_active || lastx)) begin
        m_active = 1'b1;
        hist[0] = spike_in;
        m_c = 1;
        m_ts = 0;
      end else begin
        if (m_active && m_c <= KL1) hist[m_c] = spike_in;
        if (lastx) m_active = 1'b0;
        else if (xfer) m_ts++;
        m_c++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid2 && first2 < 0) first2 = cyc - base;
      if (out_valid2) got2_q.push_back(spikes_out2);
      if (done2) done2_seen = 1'b1;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 60 && !done_seen; i++) next_cycle();
    check("wait_done", 32'(done_seen), 32'd1);
  endtask

  // Compares the transfers received so far against exp_q, in order.
  task automatic check_got(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(name, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    model_reset();
    clear_rec();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timestep", 32'(timestep_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: all ones, ready always high
    mode = 0; clear_rec(); out_ready = 1'b1;
    begin_frame();
    wait_done();
    check("t1_first_valid", 32'(first1), 32'd4);
    check("t1_last_xfer", 32'(last_rel), 32'd6);
    check("t1_done_cycle", 32'(done_rel), 32'd7);
    check("t1_busy_after", 32'(busy), 32'd0);
    exp_q = '{4'b1111, 4'b1111, 4'b1111};
    check_got("t1_vec");

    // 2: each neuron spikes only at its own timestep
    idle(20); mode = 1; clear_rec();
    begin_frame();
    wait_done();
    exp_q = '{4'b1001, 4'b0010, 4'b0100};
    check_got("t2_vec");

    // 3: ten cycles of backpressure on T0, random spikes
    idle(20); mode = 2; clear_rec(); out_ready = 1'b0;
    begin_frame();
    for (int i = 0; i < 30 && (cyc - base) < 14; i++) next_cycle();
    out_ready = 1'b1;
    wait_done();
    check("t3_first_valid", 32'(first1), 32'd4);
    check("t3_last_xfer", 32'(last_rel), 32'd16);
    check("t3_done_cycle", 32'(done_rel), 32'd17);
    check("t3_count", 32'(got_q.size()), 32'd3);

    // 4: rejected start, then start on the final transfer
    idle(20); mode = 1; clear_rec();
    begin_frame();
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && (cyc - base) < 6; i++) next_cycle();
    check("t4_ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("t4_ovr_cycle", 32'(ovr_rel), 32'd3);
    check("t4_t2_offered", 32'(out_last), 32'd1);
    begin_frame();
    wait_done();
    check("t4_no_ovr", 32'(ovr_cnt), 32'd1);
    done_seen = 1'b0;
    wait_done();
    exp_q = '{4'b1001, 4'b0010, 4'b0100, 4'b1001, 4'b0010, 4'b0100};
    check_got("t4_vec");
    check("t4_no_ovr_end", 32'(ovr_cnt), 32'd1);

    // 5: STAGGER = 2 instance
    idle(30); mode = 1; clear_rec();
    begin_frame();
    for (int i = 0; i < 60 && !done2_seen; i++) next_cycle();
    check("t5_done2", 32'(done2_seen), 32'd1);
    check("t5_first_valid", 32'(first2), 32'd7);
    check("t5_count", 32'(got2_q.size()), 32'd3);
    if (got2_q.size() == 3) begin
      check("t5_vec0", 32'(got2_q[0]), 32'd9);
      check("t5_vec1", 32'(got2_q[1]), 32'd2);
      check("t5_vec2", 32'(got2_q[2]), 32'd4);
    end

    // 6: reset in DRAIN, abort in CAPTURE, then a clean frame
    idle(20); mode = 0; clear_rec(); out_ready = 1'b0;
    begin_frame();
    for (int i = 0; i < 20 && (cyc - base) < 8; i++) next_cycle();
    check("t6_in_drain", 32'(state_dbg), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_ts", 32'(timestep_out), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);
    clear_rec();
    begin_frame();
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    idle(12);
    check("t6_abort_no_done", 32'(done_seen), 32'd0);
    check("t6_abort_no_data", 32'(got_q.size()), 32'd0);
    mode = 1; clear_rec();
    begin_frame();
    wait_done();
    exp_q = '{4'b1001, 4'b0010, 4'b0100};
    check_got("t6_vec");

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
